sdram_read_address_sequencer: RTL and testbench

SDRAM_READ_ADDRESS_SEQUENCER -- requirements
Module: sdram_read_address_sequencer

---
 rtl/sdram_read_address_sequencer.sv | 123 ++++++++++++
 tb/tb_sdram_read_address_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read_address_sequencer.sv
// Read-side pointer walker for a multi-chip SDRAM ring buffer.
// Ports: CLK, RESET (async active-low), ENABLE, ONESHOT, CLEAR, NEXT,
//   WR_ADDR/WR_CS/WR_PHASE in; R_ADDRESS_OUT, R_CHIP_SELECT, R_VALID,
//   EMPTY, DONE out; WRAP_COUNT out when READ_WRAP_COUNT_EN is defined.
module sdram_read_address_sequencer #(
  parameter int ADDR_W = 18,
  parameter int CS_W   = 1,
  parameter int STEP   = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              ONESHOT,
  input  logic              CLEAR,
  input  logic              NEXT,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [CS_W-1:0]   WR_CS,
  input  logic              WR_PHASE,
  output logic [ADDR_W-1:0] R_ADDRESS_OUT,
  output logic [CS_W-1:0]   R_CHIP_SELECT,
  output logic              R_VALID,
  output logic              EMPTY,
  output logic              DONE
`ifdef READ_WRAP_COUNT_EN
  ,
  output logic [15:0]       WRAP_COUNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] STEP_V = (ADDR_W+1)'(STEP);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CS_W-1:0]   chip_q, chip_d;
  logic              phase_q, phase_d;

  logic [ADDR_W:0]   sum;
  logic              carry;
  logic              chip_last;
  logic              advance;
  logic              lap;

  assign EMPTY = (addr_q == WR_ADDR) && (chip_q == WR_CS) &&
                 (phase_q == WR_PHASE);
  assign R_VALID = (state_q == S_RUN) && !EMPTY;
  assign DONE = (state_q == S_DONE);
  assign R_ADDRESS_OUT = addr_q;
  assign R_CHIP_SELECT = chip_q;

  // addr is always a multiple of STEP, so a carry out means
  // addr was the last slot of the current chip.
  assign sum = {1'b0, addr_q} + STEP_V;
  assign carry = sum[ADDR_W];
  assign chip_last = &chip_q;
  assign advance = NEXT && R_VALID;
  assign lap = advance && carry && chip_last;

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    chip_d = chip_q;
    phase_d = phase_q;
    if (CLEAR) begin
      state_d = S_IDLE;
      addr_d = '0;
      chip_d = '0;
      phase_d = 1'b0;
    end else begin
      if (advance) begin
        addr_d = carry ? '0 : sum[ADDR_W-1:0];
        if (carry) chip_d = chip_q + CS_W'(1);
        if (lap) phase_d = ~phase_q;
      end
      unique case (state_q)
        S_IDLE: if (ENABLE) state_d = S_RUN;
        S_RUN: begin
          if (lap && ONESHOT) state_d = S_DONE;
          else if (!ENABLE) state_d = S_IDLE;
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      chip_q <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      chip_q <= chip_d;
      phase_q <= phase_d;
    end
  end

`ifdef READ_WRAP_COUNT_EN
  logic [15:0] wrap_q, wrap_d;

  always_comb begin
    wrap_d = wrap_q;
    if (CLEAR) wrap_d = '0;
    else if (lap && wrap_q != 16'hFFFF) wrap_d = wrap_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) wrap_q <= '0;
    else wrap_q <= wrap_d;
  end

  assign WRAP_COUNT = wrap_q;
`endif

endmodule

// File: tb/tb_sdram_read_address_sequencer.sv
// Bench for sdram_read_address_sequencer: a STEP=1 instance tracked
// against an index model, and a STEP=4 instance driven from a table.
module tb_sdram_read_address_sequencer;

  logic CLK = 1'b0;
  logic RESET, ENABLE, ONESHOT, CLEAR;
  logic next_a, next_b;
  logic [3:0] wra, wrb;
  logic wcsa, wcsb, wpha, wphb;
  logic [3:0] addr_a, addr_b;
  logic cs_a, cs_b, val_a, val_b, emp_a, emp_b, done_a, done_b;
`ifdef READ_WRAP_COUNT_EN
  logic [15:0] wc_a, wc_b;
`endif

  always #5 CLK = ~CLK;

  sdram_read_address_sequencer #(.ADDR_W(4), .CS_W(1), .STEP(1)) u_a (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .ONESHOT(ONESHOT),
    .CLEAR(CLEAR), .NEXT(next_a),
    .WR_ADDR(wra), .WR_CS(wcsa), .WR_PHASE(wpha),
    .R_ADDRESS_OUT(addr_a), .R_CHIP_SELECT(cs_a), .R_VALID(val_a),
    .EMPTY(emp_a), .DONE(done_a)
`ifdef READ_WRAP_COUNT_EN
    , .WRAP_COUNT(wc_a)
`endif
  );

  sdram_read_address_sequencer #(.ADDR_W(4), .CS_W(1), .STEP(4)) u_b (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .ONESHOT(ONESHOT),
    .CLEAR(CLEAR), .NEXT(next_b),
    .WR_ADDR(wrb), .WR_CS(wcsb), .WR_PHASE(wphb),
    .R_ADDRESS_OUT(addr_b), .R_CHIP_SELECT(cs_b), .R_VALID(val_b),
    .EMPTY(emp_b), .DONE(done_b)
`ifdef READ_WRAP_COUNT_EN
    , .WRAP_COUNT(wc_b)
`endif
  );

  int npass = 0;
  int ntot = 0;

  task automatic chk(string n, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  typedef struct {
    logic [3:0] addr;
    logic       cs;
    logic       valid;
    logic       empty;
    logic       done;
    int         wc;
  } exp_t;

  exp_t sbq[$];

  // Model of instance A: linear slot index 0..63 = {phase,chip,addr}.
  int m_idx = 0;
  int m_st = 0;
  int m_wraps = 0;

  task automatic model_reset();
    m_idx = 0;
    m_st = 0;
    m_wraps = 0;
  endtask

  task automatic cyc();
    exp_t e;
    logic [5:0] p, w;
    logic emp, val, adv;
    w = {wpha, wcsa, wra};
    p = 6'(m_idx);
    emp = (p == w);
    val = (m_st == 1) && !emp;
    adv = next_a && val;
    if (CLEAR) model_reset();
    else if (m_st == 0) begin
      if (ENABLE) m_st = 1;
    end else if (m_st == 1) begin
      if (adv) begin
        m_idx = (m_idx + 1) % 64;
        if (p[4:0] == 5'h1f && m_wraps < 65535) m_wraps++;
      end
      if (adv && p[4:0] == 5'h1f && ONESHOT) m_st = 2;
      else if (!ENABLE) m_st = 0;
    end
    p = 6'(m_idx);
    e.addr = p[3:0];
    e.cs = p[4];
    e.empty = (p == w);
    e.valid = (m_st == 1) && !e.empty;
    e.done = (m_st == 2);
    e.wc = m_wraps;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    chk("a_addr", addr_a, e.addr);
    chk("a_cs", cs_a, e.cs);
    chk("a_valid", val_a, e.valid);
    chk("a_empty", emp_a, e.empty);
    chk("a_done", done_a, e.done);
`ifdef READ_WRAP_COUNT_EN
    chk("a_wrapcnt", wc_a, e.wc);
`endif
  endtask

  typedef struct {
    logic       nxt;
    logic [3:0] addr;
    logic       cs;
    logic       valid;
    logic       empty;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 4'd0,  1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 4'd4,  1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 4'd8,  1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'd8,  1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 4'd12, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 4'd0,  1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 4'd4,  1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 4'd8,  1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 4'd12, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1};

    RESET = 1'b1;
    ENABLE = 1'b0; ONESHOT = 1'b0; CLEAR = 1'b0;
    next_a = 1'b0; next_b = 1'b0;
    {wpha, wcsa, wra} = {1'b0, 1'b1, 4'd5};
    {wphb, wcsb, wrb} = {1'b1, 1'b0, 4'd0};
    #2 RESET = 1'b0;
    #10;
    chk("rst_addr", addr_a, 0);
    chk("rst_cs", cs_a, 0);
    chk("rst_valid", val_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_empty", emp_a, 0);
    chk("rst_b_valid", val_b, 0);
    @(negedge CLK);
    RESET = 1'b1;
    model_reset();

    // STEP=4 instance walks both chips then meets the write pointer.
    ENABLE = 1'b1;
    foreach (tbl[i]) begin
      next_b = tbl[i].nxt;
      cyc();
      chk($sformatf("b_addr[%0d]", i), addr_b, tbl[i].addr);
      chk($sformatf("b_cs[%0d]", i), cs_b, tbl[i].cs);
      chk($sformatf("b_valid[%0d]", i), val_b, tbl[i].valid);
      chk($sformatf("b_empty[%0d]", i), emp_b, tbl[i].empty);
    end
    next_b = 1'b0;
`ifdef READ_WRAP_COUNT_EN
    chk("b_wrapcnt", wc_b, 1);
`endif

    // Chase write pointer {0,1,5}: stops at addr 5 chip 1.
    next_a = 1'b1;
    repeat (24) cyc();
    chk("chase_addr", addr_a, 5);
    chk("chase_cs", cs_a, 1);
    chk("chase_empty", emp_a, 1);
    chk("chase_valid", val_a, 0);

    // ENABLE low drops to IDLE; NEXT ignored there.
    ENABLE = 1'b0;
    {wpha, wcsa, wra} = {1'b1, 1'b0, 4'd0};
    repeat (3) cyc();
    CLEAR = 1'b1;
    cyc();
    CLEAR = 1'b0;

    // One-shot pass with ONESHOT toggled mid-pass.
    ENABLE = 1'b1;
    for (int i = 0; i < 38; i++) begin
      ONESHOT = (i < 10 || i > 20);
      cyc();
    end
    chk("os_done", done_a, 1);
    chk("os_valid", val_a, 0);
    chk("os_empty", emp_a, 1);
    CLEAR = 1'b1;
    cyc();
    CLEAR = 1'b0;
    chk("os_clr_done", done_a, 0);
    chk("os_clr_addr", addr_a, 0);
    ONESHOT = 1'b0;

    // CLEAR beats NEXT at addr 7.
    repeat (8) cyc();
    chk("pre_clr_addr", addr_a, 7);
    CLEAR = 1'b1;
    cyc();
    CLEAR = 1'b0;
    chk("clr_addr", addr_a, 0);
    chk("clr_valid", val_a, 0);

    // Async reset between edges at addr 9.
    repeat (10) cyc();
    chk("pre_rst_addr", addr_a, 9);
    #2 RESET = 1'b0;
    #1;
    chk("arst_addr", addr_a, 0);
    chk("arst_cs", cs_a, 0);
    chk("arst_valid", val_a, 0);
    chk("arst_done", done_a, 0);
`ifdef READ_WRAP_COUNT_EN
    chk("arst_wrapcnt", wc_a, 0);
`endif
    #1 RESET = 1'b1;
    model_reset();
    repeat (34) cyc();
    chk("lap_addr", addr_a, 0);
    chk("lap_empty", emp_a, 1);
`ifdef READ_WRAP_COUNT_EN
    chk("lap_wrapcnt", wc_a, 1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 200; i++) begin
      if (i % 20 == 0)
        {wpha, wcsa, wra} = 6'($urandom_range(0, 63));
      next_a = $urandom_range(0, 1);
      ENABLE = ($urandom_range(0, 9) != 0);
      ONESHOT = $urandom_range(0, 1);
      CLEAR = ($urandom_range(0, 29) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
